// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if: WB-stage, debug-write and register-file port bundle of the write arbiter.
interface wb_write_arbiter_if #(
  parameter int NBITS = 32,
  parameter int REGS  = 5
);
  logic             i_wb_we;
  logic [REGS-1:0]  i_wb_reg;
  logic [NBITS-1:0] i_wb_data;
  logic             i_dbg_valid;
  logic [REGS-1:0]  i_dbg_reg;
  logic [NBITS-1:0] i_dbg_data;
  logic             o_dbg_ready;
  logic             o_stall;
  logic             o_grant_dbg;
  logic             o_rf_we;
  logic [REGS-1:0]  o_rf_reg;
  logic [NBITS-1:0] o_rf_data;
  modport master (
    output i_wb_we, i_wb_reg, i_wb_data, i_dbg_valid, i_dbg_reg, i_dbg_data,
    input  o_dbg_ready, o_stall, o_grant_dbg, o_rf_we, o_rf_reg, o_rf_data
  );
  modport slave (
    input  i_wb_we, i_wb_reg, i_wb_data, i_dbg_valid, i_dbg_reg, i_dbg_data,
    output o_dbg_ready, o_stall, o_grant_dbg, o_rf_we, o_rf_reg, o_rf_data
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: register-file write port arbiter, WB first, debug guaranteed progress via starvation counter.
module wb_write_arbiter #(
  parameter int NBITS      = 32,
  parameter int REGS       = 5,
  parameter int STARVE_MAX = 4,
  parameter int CNT_BITS   = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  wb_write_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                rf_we_q, rf_we_d, grant_q, grant_d;
  logic [REGS-1:0]     rf_reg_q, rf_reg_d;
  logic [NBITS-1:0]    rf_data_q, rf_data_d;
  logic                wb_req, forced, dbg_acc, blocked;
  assign wb_req  = bus.i_wb_we & (bus.i_wb_reg != '0);
  assign forced  = state_q == FORCE;
  assign bus.o_dbg_ready = !i_reset & (forced | !wb_req);
  assign bus.o_stall     = !i_reset & forced;
  assign dbg_acc = bus.i_dbg_valid & bus.o_dbg_ready;
  assign blocked = !forced & bus.i_dbg_valid & wb_req;
  // Counting up to STARVE_MAX on the forcing step leaves cnt==STARVE_MAX while in FORCE.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    if (blocked) begin
      state_d = (cnt_q == CNT_BITS'(STARVE_MAX - 1)) ? FORCE : WAIT;
      cnt_d   = cnt_q + 1'b1;
    end
  end
  always_comb begin
    rf_we_d   = 1'b0;
    grant_d   = 1'b0;
    rf_reg_d  = rf_reg_q;
    rf_data_d = rf_data_q;
    if (dbg_acc) begin
      rf_we_d   = bus.i_dbg_reg != '0;
      grant_d   = 1'b1;
      rf_reg_d  = bus.i_dbg_reg;
      rf_data_d = bus.i_dbg_data;
    end else if (wb_req & !forced) begin
      rf_we_d   = 1'b1;
      rf_reg_d  = bus.i_wb_reg;
      rf_data_d = bus.i_wb_data;
    end
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rf_we_q   <= 1'b0;
      grant_q   <= 1'b0;
      rf_reg_q  <= '0;
      rf_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rf_we_q   <= rf_we_d;
      grant_q   <= grant_d;
      rf_reg_q  <= rf_reg_d;
      rf_data_q <= rf_data_d;
    end
  end
  assign bus.o_rf_we     = rf_we_q;
  assign bus.o_grant_dbg = grant_q;
  assign bus.o_rf_reg    = rf_reg_q;
  assign bus.o_rf_data   = rf_data_q;
endmodule
